// File: rtl/toy_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// toy_fetch_queue_pkg
//   Shared definitions for the RISC_TOY instruction-fetch front end.
//   - ADDR_W / INSTR_W : word-address and instruction widths
//   - RESET_ADDR_DEF   : default word address fetched first after reset
//   - fetch_entry_t    : one queue entry, an instruction tagged with its PC
// ---------------------------------------------------------------------------
package toy_fetch_queue_pkg;

  localparam int ADDR_W  = 30;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = '0;

  // Entry layout: instruction in the upper bits, its word address below.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/toy_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// toy_fetch_queue_if
//   Bundles the fetch front end's three bus groups:
//   - instruction memory : IREQ, IADDR (out of fetch), INSTR (into fetch)
//   - execute redirect   : REDIR_VALID, REDIR_ADDR (into fetch)
//   - decode handshake   : DEC_VALID, DEC_INSTR, DEC_PC (out), DEC_READY (in)
//   Modport master is the fetch queue; modport slave is its environment.
//
//   Handshake semantics (decode side): DEC_VALID/DEC_INSTR/DEC_PC describe
//   the head entry. A transfer happens on a rising edge where
//   DEC_VALID & DEC_READY are both high and REDIR_VALID is low. DEC_VALID
//   does not depend on DEC_READY; while DEC_VALID is low the payload is
//   stale and must be ignored. A redirect flushes the queue, and a
//   same-cycle DEC_VALID & DEC_READY is then not a transfer.
// ---------------------------------------------------------------------------
interface toy_fetch_queue_if
  import toy_fetch_queue_pkg::*;
();

  logic               IREQ;
  logic [ADDR_W-1:0]  IADDR;
  logic [INSTR_W-1:0] INSTR;

  logic               REDIR_VALID;
  logic [ADDR_W-1:0]  REDIR_ADDR;

  logic               DEC_VALID;
  logic [INSTR_W-1:0] DEC_INSTR;
  logic [ADDR_W-1:0]  DEC_PC;
  logic               DEC_READY;

  modport master (
    output IREQ,
    output IADDR,
    input  INSTR,
    input  REDIR_VALID,
    input  REDIR_ADDR,
    output DEC_VALID,
    output DEC_INSTR,
    output DEC_PC,
    input  DEC_READY
  );

  modport slave (
    input  IREQ,
    input  IADDR,
    output INSTR,
    output REDIR_VALID,
    output REDIR_ADDR,
    input  DEC_VALID,
    input  DEC_INSTR,
    input  DEC_PC,
    output DEC_READY
  );

endinterface

// File: rtl/toy_fetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// toy_fetch_queue_sync_fifo
//   Small synchronous FIFO with show-ahead head output and synchronous flush.
//   Ports:
//     CLK, RSTN   clock / asynchronous active-low reset
//     push        write push_data at the tail (ignored when full)
//     push_data   WIDTH-bit entry
//     pop         advance the head (ignored when empty)
//     flush       empty the FIFO; wins over push and pop
//     count       number of valid entries (log2(DEPTH)+1 bits)
//     head        storage at the read pointer, no extra latency
// ---------------------------------------------------------------------------
module toy_fetch_queue_sync_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The owner never overfills or underflows; the guards only keep the
  // pointers and count coherent if it ever did.
  assign do_push = push & (count != FULL_CNT);
  assign do_pop  = pop  & (count != '0);

  assign head = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Storage is left as is: the head keeps a stale value that nobody
      // looks at while count is zero.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/toy_fetch_queue.sv
// ---------------------------------------------------------------------------
// toy_fetch_queue
//   Instruction-fetch front end for the RISC_TOY pipeline. Owns the fetch PC,
//   requests synchronous instruction memory, captures the instruction one
//   cycle later, tags it with its PC and buffers it for decode. A taken
//   branch/jump from execute flushes the queue and restarts fetch.
//   Parameters:
//     DEPTH       queue entries (power of two, >= 2)
//     RESET_ADDR  word address fetched first after reset
//   Ports:
//     CLK   clock, rising edge
//     RSTN  asynchronous active-low reset
//     bus   toy_fetch_queue_if.master: IREQ/IADDR/INSTR to memory,
//           REDIR_VALID/REDIR_ADDR from execute, DEC_* handshake to decode
// ---------------------------------------------------------------------------
module toy_fetch_queue
  import toy_fetch_queue_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic                CLK,
  input  logic                RSTN,
  toy_fetch_queue_if.master   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  // One spare bit so count + resp_pend can never wrap.
  localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              resp_pend;
  logic              started;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    in_flight;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Slots already committed: queued entries plus the response on its way.
  // A pop in this same cycle is deliberately not credited, so every issued
  // request is guaranteed a slot when its response lands.
  assign in_flight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, resp_pend};

  assign issue = started & ~bus.REDIR_VALID & (in_flight < CREDIT_LIM);

  // A redirect in the response cycle means the response is wrong-path.
  assign push = resp_pend & ~bus.REDIR_VALID;
  assign pop  = bus.DEC_VALID & bus.DEC_READY & ~bus.REDIR_VALID;

  assign push_entry = '{instr: bus.INSTR, pc: pend_pc};

  assign bus.IREQ      = issue;
  assign bus.IADDR     = pc;
  assign bus.DEC_VALID = (fifo_count != '0);
  assign bus.DEC_INSTR = head_entry.instr;
  assign bus.DEC_PC    = head_entry.pc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc        <= RESET_ADDR;
      pend_pc   <= '0;
      resp_pend <= 1'b0;
      started   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (bus.REDIR_VALID) begin
        pc        <= bus.REDIR_ADDR;
        resp_pend <= 1'b0;
      end else begin
        resp_pend <= issue;
        if (issue) begin
          // Natural 30-bit wrap from the top of the address space to zero.
          pc      <= pc + ADDR_W'(1);
          pend_pc <= pc;
        end
      end
    end
  end

  toy_fetch_queue_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.REDIR_VALID),
    .count     (fifo_count),
    .head      (head_entry)
  );

endmodule
